// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, widths and bit-timing derivation.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned clock_per_bit(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Offset from the start edge to the middle of a bit.
  function automatic int unsigned half_bit(input int unsigned cpb);
    return cpb >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bus: received byte plus status pulses.
interface uart_rx_if;
  logic [uart_pkg::DATA_W-1:0] data_out;
  logic                        data_valid;
  logic                        frame_err;
  logic                        busy;

  modport master (output data_out, data_valid, frame_err, busy);
  modport slave  (input  data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both reset to RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, frame-error detection, break lockout.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 100000000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master out_if
);

  localparam int unsigned CLOCK_PER_BIT = clock_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT      = half_bit(CLOCK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLOCK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  uart_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              frame_err_q;
  logic              busy_q;
  logic              armed;
  logic              rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Receive FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      armed        <= 1'b1;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state  <= START;
            cnt    <= CNT_HALF;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_s) begin
            state   <= DATA;
            cnt     <= CNT_BIT;
            bit_idx <= '0;
          end else begin
            // Start bit gone by mid-bit: a glitch, drop it silently.
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift_q <= {rx_s, shift_q[DATA_W-1:1]};
            cnt     <= CNT_BIT;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Return to IDLE mid stop bit so back-to-back frames are caught.
            state  <= IDLE;
            busy_q <= 1'b0;
            if (rx_s) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              armed       <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_if.data_out   = data_out_q;
  assign out_if.data_valid = data_valid_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .BAUD_RATE  (10),
    .CLOCK_FREQ (160)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .out_if (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int       dv_cnt   = 0;
  int       fe_cnt   = 0;
  int       both_cnt = 0;
  int       long_cnt = 0;
  logic     dv_prev  = 1'b0;
  logic     fe_prev  = 1'b0;
  logic [7:0] dv_log[$];

  // Pulse monitor: counts and logs outputs as seen at each rising edge.
  always @(posedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_log.push_back(bus.data_out);
    end
    if (bus.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (bus.data_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt = both_cnt + 1;
    if ((bus.data_valid === 1'b1 && dv_prev) || (bus.frame_err === 1'b1 && fe_prev))
      long_cnt = long_cnt + 1;
    dv_prev = (bus.data_valid === 1'b1);
    fe_prev = (bus.frame_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  int dv0, fe0, lg0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    check("rst_data_out",   32'(bus.data_out),   32'h00);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_frame_err",  32'(bus.frame_err),  32'h0);
    check("rst_busy",       32'(bus.busy),       32'h0);
    rst = 1'b0;
    tick(CPB);

    // Single frame 0xA5
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    tick(20);
    check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("a5_data_out", 32'(bus.data_out), 32'hA5);
    check("a5_no_fe",    32'(fe_cnt - fe0), 32'd0);
    check("a5_busy_low", 32'(bus.busy),     32'h0);

    // Back-to-back 0x00 then 0xFF
    dv0 = dv_cnt; lg0 = dv_log.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
    if (dv_log.size() >= lg0 + 2) begin
      check("b2b_first",  32'(dv_log[lg0]),     32'h00);
      check("b2b_second", 32'(dv_log[lg0 + 1]), 32'hFF);
    end else begin
      check("b2b_log_size", 32'(dv_log.size() - lg0), 32'd2);
    end
    check("b2b_data_out", 32'(bus.data_out), 32'hFF);

    // Glitch: 4 clocks low
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(10);
    check("glitch_busy_low", 32'(bus.busy),     32'h0);
    check("glitch_no_dv",    32'(dv_cnt - dv0), 32'd0);
    check("glitch_no_fe",    32'(fe_cnt - fe0), 32'd0);
    tick(CPB);

    // Frame 0x3C with a bad stop bit
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    tick(2 * CPB);
    check("ferr_fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_no_dv",    32'(dv_cnt - dv0), 32'd0);
    check("ferr_data_out", 32'(bus.data_out), 32'hFF);

    // Break: 40 bit times low, then 0x5A
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    tick(40 * CPB);
    check("break_fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("break_no_dv",    32'(dv_cnt - dv0), 32'd0);
    rx = 1'b1;
    tick(3 * CPB);
    send_frame(8'h5A, 1'b1);
    tick(20);
    check("break_5a_dv",       32'(dv_cnt - dv0), 32'd1);
    check("break_5a_data_out", 32'(bus.data_out), 32'h5A);
    check("break_fe_final",    32'(fe_cnt - fe0), 32'd1);

    // Reset during bit 4 of 0x81, frame abandoned, then 0x7E
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      tick(CPB);
    end
    rx = 1'b0;
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rx = 1'b1;
    tick(1);
    check("midrst_data_out", 32'(bus.data_out),   32'h00);
    check("midrst_busy",     32'(bus.busy),       32'h0);
    check("midrst_dv",       32'(bus.data_valid), 32'h0);
    check("midrst_fe",       32'(bus.frame_err),  32'h0);
    rst = 1'b0;
    tick(3 * CPB);
    check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("midrst_no_fe", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h7E, 1'b1);
    tick(20);
    check("midrst_7e_dv",       32'(dv_cnt - dv0), 32'd1);
    check("midrst_7e_data_out", 32'(bus.data_out), 32'h7E);

    // Global pulse properties
    check("pulses_exclusive",  32'(both_cnt), 32'd0);
    check("pulses_one_cycle",  32'(long_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
